rf_wr_arb: RTL and testbench

Write-port arbiter for the 16-entry register file. It shares the file's single write port between two writeback sources: the ALU result path and the data-memory load path. Each source gets a one-entry holding slot and a valid/ready handshake, and the block flags read-after-write hazards on the two read ports. It sits between the execute/memory stages and the register file's `wr_en`/`wr_addr`/`dat_in` inputs.

---
 rtl/rf_arb_pkg.sv | 17 +
 rtl/rf_wr_slot.sv | 52 +++++
 rtl/rf_wr_arb.sv | 159 +++++++++++++++
 tb/tb_rf_wr_arb.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and default sizes for the register-file write-port arbiter.
package rf_arb_pkg;

   localparam int DEF_PW = 4;
   localparam int DEF_DW = 8;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } src_e;

   typedef struct packed {
      logic [DEF_PW-1:0] addr;
      logic [DEF_DW-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/rf_wr_slot.sv
// One-entry writeback holding slot: storage, full flag, ready logic and read-hazard compare.
module rf_wr_slot #(
   parameter int PW = 4,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [PW-1:0] in_addr,
   input  logic [DW-1:0] in_data,
   input  logic          grant,
   input  logic [PW-1:0] rd_addr_a,
   input  logic [PW-1:0] rd_addr_b,
   output logic          ready,
   output logic          full,
   output logic [PW-1:0] addr,
   output logic [DW-1:0] data,
   output logic          hz_a,
   output logic          hz_b
);

   logic          full_reg;
   logic [PW-1:0] addr_reg;
   logic [DW-1:0] data_reg;
   logic          capture;

   assign ready = ~full_reg | grant;

   // A grant while empty is a bypass write: the request leaves directly and is not stored.
   assign capture = in_valid & ready & ~(grant & ~full_reg);

   always_ff @(posedge clk) begin
      if (reset) begin
         full_reg <= 1'b0;
         addr_reg <= '0;
         data_reg <= '0;
      end else if (capture) begin
         full_reg <= 1'b1;
         addr_reg <= in_addr;
         data_reg <= in_data;
      end else if (grant) begin
         full_reg <= 1'b0;
      end
   end

   assign full = full_reg;
   assign addr = addr_reg;
   assign data = data_reg;
   assign hz_a = full_reg & (addr_reg == rd_addr_a);
   assign hz_b = full_reg & (addr_reg == rd_addr_b);

endmodule

// File: rtl/rf_wr_arb.sv
// Shares the register-file write port between the ALU and load writeback slots.
// Build option RF_WR_ARB_BYPASS_EN: an empty-slot request may be written in its own accept cycle.
module rf_wr_arb
   import rf_arb_pkg::*;
#(
   parameter int PW = rf_arb_pkg::DEF_PW,
   parameter int DW = rf_arb_pkg::DEF_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          alu_valid,
   input  logic [PW-1:0] alu_addr,
   input  logic [DW-1:0] alu_data,
   output logic          alu_ready,
   input  logic          mem_valid,
   input  logic [PW-1:0] mem_addr,
   input  logic [DW-1:0] mem_data,
   output logic          mem_ready,
   input  logic [PW-1:0] rd_addrA,
   input  logic [PW-1:0] rd_addrB,
   output logic          hz_a,
   output logic          hz_b,
   output logic          wr_en,
   output logic [PW-1:0] wr_addr,
   output logic [DW-1:0] wr_data,
   output logic          busy
);

   // Index 0 is the ALU source, index 1 the load source.
   logic [1:0]    in_valid;
   logic [1:0]    full;
   logic [1:0]    ready;
   logic [1:0]    grant;
   logic [1:0]    cand;
   logic [1:0]    hz_a_v;
   logic [1:0]    hz_b_v;
   logic [PW-1:0] in_addr   [2];
   logic [DW-1:0] in_data   [2];
   logic [PW-1:0] slot_addr [2];
   logic [DW-1:0] slot_data [2];
   logic [PW-1:0] cand_addr [2];
   logic [DW-1:0] cand_data [2];

   src_e last_grant_reg;
   src_e last_grant_next;
   src_e grant_src;
   logic grant_any;

   assign in_valid   = {mem_valid, alu_valid};
   assign in_addr[0] = alu_addr;
   assign in_addr[1] = mem_addr;
   assign in_data[0] = alu_data;
   assign in_data[1] = mem_data;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_slot
         rf_wr_slot #(
            .PW(PW),
            .DW(DW)
         ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .in_valid (in_valid[gi]),
            .in_addr  (in_addr[gi]),
            .in_data  (in_data[gi]),
            .grant    (grant[gi]),
            .rd_addr_a(rd_addrA),
            .rd_addr_b(rd_addrB),
            .ready    (ready[gi]),
            .full     (full[gi]),
            .addr     (slot_addr[gi]),
            .data     (slot_data[gi]),
            .hz_a     (hz_a_v[gi]),
            .hz_b     (hz_b_v[gi])
         );

         // An empty slot can only be a candidate through bypass, so it presents the live request.
         assign cand_addr[gi] = full[gi] ? slot_addr[gi] : in_addr[gi];
         assign cand_data[gi] = full[gi] ? slot_data[gi] : in_data[gi];
      end
   endgenerate

`ifdef RF_WR_ARB_BYPASS_EN
   assign cand = full | in_valid;
`else
   assign cand = full;
`endif

   always_comb begin
      grant_any = 1'b0;
      grant_src = SRC_ALU;
      if (!reset) begin
         case (cand)
            2'b01: begin
               grant_any = 1'b1;
               grant_src = SRC_ALU;
            end
            2'b10: begin
               grant_any = 1'b1;
               grant_src = SRC_MEM;
            end
            2'b11: begin
               grant_any = 1'b1;
               // Same destination: the ALU result is the younger write, so it must land last.
               if (cand_addr[0] == cand_addr[1]) begin
                  grant_src = SRC_MEM;
               end else if (last_grant_reg == SRC_MEM) begin
                  grant_src = SRC_ALU;
               end else begin
                  grant_src = SRC_MEM;
               end
            end
            default: begin
               grant_any = 1'b0;
            end
         endcase
      end
   end

   assign grant[0] = grant_any & (grant_src == SRC_ALU);
   assign grant[1] = grant_any & (grant_src == SRC_MEM);

   always_comb begin
      last_grant_next = last_grant_reg;
      if (grant_any) begin
         last_grant_next = grant_src;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_reg <= SRC_MEM;
      end else begin
         last_grant_reg <= last_grant_next;
      end
   end

   always_comb begin
      wr_en   = grant_any;
      wr_addr = '0;
      wr_data = '0;
      if (grant_any) begin
         if (grant_src == SRC_MEM) begin
            wr_addr = cand_addr[1];
            wr_data = cand_data[1];
         end else begin
            wr_addr = cand_addr[0];
            wr_data = cand_data[0];
         end
      end
   end

   assign alu_ready = ready[0];
   assign mem_ready = ready[1];
   assign busy      = ~reset & (|full);
   assign hz_a      = ~reset & (|hz_a_v);
   assign hz_b      = ~reset & (|hz_b_v);

endmodule

// File: tb/tb_rf_wr_arb.sv
// Self-checking bench for rf_wr_arb: directed scenarios plus randomized traffic against a cycle model.
module tb_rf_wr_arb;
   import rf_arb_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       alu_valid = 1'b0;
   logic [3:0] alu_addr = '0;
   logic [7:0] alu_data = '0;
   logic       alu_ready;
   logic       mem_valid = 1'b0;
   logic [3:0] mem_addr = '0;
   logic [7:0] mem_data = '0;
   logic       mem_ready;
   logic [3:0] rd_addrA = '0;
   logic [3:0] rd_addrB = '0;
   logic       hz_a, hz_b, wr_en, busy;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;

   rf_wr_arb #(.PW(4), .DW(8)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
      .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .hz_a(hz_a), .hz_b(hz_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
   );

   always #5 clk = ~clk;

`ifdef RF_WR_ARB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // stimulus for the next cycle (index 0 = ALU, 1 = MEM)
   bit         iv [2];
   logic [3:0] ia [2];
   logic [7:0] id [2];
   logic [3:0] ra, rb;
   bit         rst;

   // reference model: pending write per source, last winner, register file
   bit         pv [2];
   logic [3:0] pa [2];
   logic [7:0] pd [2];
   int         lg;
   int         e_g;
   bit         e_wr_en;
   logic [3:0] e_wr_addr;
   logic [7:0] e_wr_data;
   bit         e_rdy [2];
   bit         e_hz_a, e_hz_b, e_busy;
   int         acc_cnt;
   logic [7:0] oreg [16];
   logic [7:0] mreg [16];
   wb_req_t    obs_q [$];
   wb_req_t    mw_q [$];

   task automatic model_eval();
      bit         c [2];
      logic [3:0] ca [2];
      logic [7:0] cd [2];
      e_g = -1;
      for (int s = 0; s < 2; s++) begin
         c[s]  = pv[s] || (BYP && iv[s]);
         ca[s] = pv[s] ? pa[s] : ia[s];
         cd[s] = pv[s] ? pd[s] : id[s];
      end
      if (!rst) begin
         if (c[0] && c[1]) e_g = (ca[0] == ca[1]) ? 1 : ((lg == 1) ? 0 : 1);
         else if (c[0]) e_g = 0;
         else if (c[1]) e_g = 1;
      end
      e_wr_en   = (e_g >= 0);
      e_wr_addr = (e_g >= 0) ? ca[e_g] : 4'd0;
      e_wr_data = (e_g >= 0) ? cd[e_g] : 8'd0;
      for (int s = 0; s < 2; s++) e_rdy[s] = !pv[s] || (e_g == s);
      e_hz_a = !rst && ((pv[0] && pa[0] == ra) || (pv[1] && pa[1] == ra));
      e_hz_b = !rst && ((pv[0] && pa[0] == rb) || (pv[1] && pa[1] == rb));
      e_busy = !rst && (pv[0] || pv[1]);
   endtask

   task automatic model_commit();
      wb_req_t w;
      if (rst) begin
         pv[0] = 1'b0;
         pv[1] = 1'b0;
         lg    = 1;
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (iv[s] && e_rdy[s]) acc_cnt++;
            if (iv[s] && e_rdy[s] && !(e_g == s && !pv[s])) begin
               pv[s] = 1'b1;
               pa[s] = ia[s];
               pd[s] = id[s];
            end else if (e_g == s) begin
               pv[s] = 1'b0;
            end
         end
         if (e_g >= 0) begin
            lg = e_g;
            mreg[e_wr_addr] = e_wr_data;
            w.addr = e_wr_addr;
            w.data = e_wr_data;
            mw_q.push_back(w);
         end
      end
   endtask

   // One clock cycle: drive after the edge, evaluate at the falling edge, then advance the model.
   task automatic apply();
      wb_req_t w;
      @(posedge clk);
      #1;
      reset = rst;
      alu_valid = iv[0]; alu_addr = ia[0]; alu_data = id[0];
      mem_valid = iv[1]; mem_addr = ia[1]; mem_data = id[1];
      rd_addrA = ra; rd_addrB = rb;
      @(negedge clk);
      model_eval();
      if (wr_en === 1'b1) begin
         oreg[wr_addr] = wr_data;
         w.addr = wr_addr;
         w.data = wr_data;
         obs_q.push_back(w);
         $display("[TB] t=%0t write r%0d <= 0x%02h", $time, wr_addr, wr_data);
      end
      model_commit();
   endtask

   task automatic set_idle();
      iv[0] = 1'b0; iv[1] = 1'b0;
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1'b1;
      apply();
      rst = 1'b0;
      obs_q.delete();
      mw_q.delete();
      acc_cnt = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      iv[0] = 1'b1; ia[0] = 4'd9; id[0] = 8'h77;
      iv[1] = 1'b1; ia[1] = 4'd9; id[1] = 8'h66;
      for (int k = 0; k < 2; k++) begin
         apply();
         n_tests++;
         if (wr_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold cyc%0d: wr_en=%b busy=%b, need 0 0", k, wr_en, busy);
         end
      end
      rst = 1'b0;
      set_idle();
      apply();
      n_tests++;
      if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: alu_ready=%b mem_ready=%b, need 1 1", alu_ready, mem_ready);
      end
      n_tests++;
      if (wr_en !== 1'b0 || wr_addr !== 4'd0 || wr_data !== 8'd0 || hz_a !== 1'b0 || hz_b !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: en=%b a=%0d d=%02h hz=%b%b, need all 0", wr_en, wr_addr, wr_data, hz_a, hz_b);
      end
   endtask

   task automatic test_single_alu();
      do_reset();
      ra = 4'd3; rb = 4'd0;
      iv[0] = 1'b1; ia[0] = 4'd3; id[0] = 8'h5A;
      apply();
`ifdef RF_WR_ARB_BYPASS_EN
      n_tests++;
      if (wr_en !== 1'b1 || wr_addr !== 4'd3 || wr_data !== 8'h5A || hz_a !== 1'b0) begin
         n_fail++;
         $display("FAIL single_bypass: en=%b a=%0d d=%02h hz_a=%b, need 1 3 5a 0", wr_en, wr_addr, wr_data, hz_a);
      end
`else
      n_tests++;
      if (wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL single_accept: wr_en=%b, need 0", wr_en);
      end
`endif
      set_idle();
      apply();
`ifdef RF_WR_ARB_BYPASS_EN
      n_tests++;
      if (wr_en !== 1'b0 || hz_a !== 1'b0) begin
         n_fail++;
         $display("FAIL single_after: en=%b hz_a=%b, need 0 0", wr_en, hz_a);
      end
`else
      n_tests++;
      if (wr_en !== 1'b1 || wr_addr !== 4'd3 || wr_data !== 8'h5A || hz_a !== 1'b1) begin
         n_fail++;
         $display("FAIL single_write: en=%b a=%0d d=%02h hz_a=%b, need 1 3 5a 1", wr_en, wr_addr, wr_data, hz_a);
      end
`endif
      n_tests++;
      if (busy !== e_busy || hz_b !== e_hz_b) begin
         n_fail++;
         $display("FAIL single_busy: busy=%b hz_b=%b, need %b %b", busy, hz_b, e_busy, e_hz_b);
      end
   endtask

   task automatic test_tie();
      do_reset();
      iv[0] = 1'b1; ia[0] = 4'd2; id[0] = 8'h11;
      iv[1] = 1'b1; ia[1] = 4'd7; id[1] = 8'h22;
      apply();
      set_idle();
      for (int k = 0; k < 3; k++) apply();
      n_tests++;
      if (obs_q.size() != 2) begin
         n_fail++;
         $display("FAIL tie_count: %0d writes, need 2", obs_q.size());
      end else begin
         n_tests++;
         if (obs_q[0].addr !== 4'd2 || obs_q[0].data !== 8'h11 || obs_q[1].addr !== 4'd7 || obs_q[1].data !== 8'h22) begin
            n_fail++;
            $display("FAIL tie_order: r%0d=%02h,r%0d=%02h, need r2=11,r7=22",
                     obs_q[0].addr, obs_q[0].data, obs_q[1].addr, obs_q[1].data);
         end
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL tie_drain: busy=%b, need 0", busy);
      end
   endtask

   task automatic test_same_addr();
      do_reset();
      iv[0] = 1'b1; ia[0] = 4'd4; id[0] = 8'hAA;
      iv[1] = 1'b1; ia[1] = 4'd4; id[1] = 8'hBB;
      apply();
      set_idle();
      for (int k = 0; k < 3; k++) apply();
      n_tests++;
      if (obs_q.size() != 2) begin
         n_fail++;
         $display("FAIL same_addr_count: %0d writes, need 2", obs_q.size());
      end else begin
         n_tests++;
         if (obs_q[0].data !== 8'hBB || obs_q[1].data !== 8'hAA) begin
            n_fail++;
            $display("FAIL same_addr_order: first=%02h second=%02h, need bb then aa", obs_q[0].data, obs_q[1].data);
         end
      end
      n_tests++;
      if (oreg[4] !== 8'hAA) begin
         n_fail++;
         $display("FAIL same_addr_final: reg4=%02h, need aa", oreg[4]);
      end
   endtask

   task automatic test_dual_load();
      do_reset();
      for (int k = 0; k < 10; k++) begin
         iv[0] = 1'b1; ia[0] = 4'd1; id[0] = 8'(k);
         iv[1] = 1'b1; ia[1] = 4'd2; id[1] = 8'(8'h80 + k);
         apply();
         n_tests++;
         if (wr_en !== e_wr_en || (e_wr_en && (wr_addr !== e_wr_addr || wr_data !== e_wr_data))) begin
            n_fail++;
            $display("FAIL dual_wr cyc%0d: en=%b a=%0d d=%02h, need en=%b a=%0d d=%02h",
                     k, wr_en, wr_addr, wr_data, e_wr_en, e_wr_addr, e_wr_data);
         end
         n_tests++;
         if (alu_ready !== e_rdy[0] || mem_ready !== e_rdy[1]) begin
            n_fail++;
            $display("FAIL dual_ready cyc%0d: alu=%b mem=%b, need %b %b", k, alu_ready, mem_ready, e_rdy[0], e_rdy[1]);
         end
         if (k >= 1) begin
            n_tests++;
            if (wr_en !== 1'b1) begin
               n_fail++;
               $display("FAIL dual_rate cyc%0d: wr_en=%b, need 1", k, wr_en);
            end
         end
      end
      set_idle();
      for (int k = 0; k < 3; k++) apply();
      n_tests++;
      if (obs_q.size() != acc_cnt) begin
         n_fail++;
         $display("FAIL dual_count: %0d writes, need %0d", obs_q.size(), acc_cnt);
      end
      for (int i = 1; i < obs_q.size(); i++) begin
         n_tests++;
         if (obs_q[i].addr === obs_q[i-1].addr) begin
            n_fail++;
            $display("FAIL dual_alternate write%0d: r%0d twice in a row", i, obs_q[i].addr);
         end
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      iv[0] = 1'b1; ia[0] = 4'd5; id[0] = 8'hC3;
      iv[1] = 1'b1; ia[1] = 4'd6; id[1] = 8'h3C;
      apply();
      set_idle();
      rst = 1'b1;
      apply();
      n_tests++;
      if (wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_write: wr_en=%b a=%0d d=%02h, need 0", wr_en, wr_addr, wr_data);
      end
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         apply();
         n_tests++;
         if (busy !== 1'b0 || wr_en !== 1'b0 || wr_data === 8'hC3 || wr_data === 8'h3C) begin
            n_fail++;
            $display("FAIL mid_reset_after cyc%0d: busy=%b en=%b d=%02h, need 0 0 00", k, busy, wr_en, wr_data);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 400; k++) begin
         rst = ($urandom_range(0, 49) == 0);
         for (int s = 0; s < 2; s++) begin
            iv[s] = ($urandom_range(0, 9) < 6);
            ia[s] = 4'($urandom_range(0, 3));
            id[s] = 8'($urandom);
         end
         ra = 4'($urandom_range(0, 4));
         rb = 4'($urandom_range(0, 4));
         apply();
         n_tests++;
         if (wr_en !== e_wr_en || (e_wr_en && (wr_addr !== e_wr_addr || wr_data !== e_wr_data))) begin
            n_fail++;
            $display("FAIL rnd_wr cyc%0d: en=%b a=%0d d=%02h, need en=%b a=%0d d=%02h",
                     k, wr_en, wr_addr, wr_data, e_wr_en, e_wr_addr, e_wr_data);
         end
         n_tests++;
         if (alu_ready !== e_rdy[0] || mem_ready !== e_rdy[1] || busy !== e_busy) begin
            n_fail++;
            $display("FAIL rnd_ctrl cyc%0d: rdy=%b%b busy=%b, need %b%b %b",
                     k, alu_ready, mem_ready, busy, e_rdy[0], e_rdy[1], e_busy);
         end
         n_tests++;
         if (hz_a !== e_hz_a || hz_b !== e_hz_b) begin
            n_fail++;
            $display("FAIL rnd_hazard cyc%0d: hz=%b%b, need %b%b", k, hz_a, hz_b, e_hz_a, e_hz_b);
         end
      end
      rst = 1'b0;
      set_idle();
      for (int k = 0; k < 3; k++) apply();
      n_tests++;
      if (obs_q.size() != mw_q.size()) begin
         n_fail++;
         $display("FAIL rnd_count: %0d writes, need %0d", obs_q.size(), mw_q.size());
      end
      for (int r = 0; r < 16; r++) begin
         n_tests++;
         if (oreg[r] !== mreg[r]) begin
            n_fail++;
            $display("FAIL rnd_regfile r%0d: %02h, need %02h", r, oreg[r], mreg[r]);
         end
      end
   endtask

   initial begin
      for (int r = 0; r < 16; r++) begin
         oreg[r] = 8'd0;
         mreg[r] = 8'd0;
      end
      pv[0] = 1'b0; pv[1] = 1'b0;
      pa[0] = '0; pa[1] = '0; pd[0] = '0; pd[1] = '0;
      ia[0] = '0; ia[1] = '0; id[0] = '0; id[1] = '0;
      ra = '0; rb = '0;
      lg = 1;
      acc_cnt = 0;
      rst = 1'b1;
      set_idle();
      test_reset();
      test_single_alu();
      test_tie();
      test_same_addr();
      test_dual_load();
      test_mid_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
